riscv_mem_arbiter: RTL
======================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive fetch denials before forced fetch grant (range 1..15).
REQ-004 SHALL have ports: clk input 1, single clock; rst input 1, reset, asynchronous, active-high.
REQ-005 SHALL have fetch ports: if_req in 1, if_addr in AW, if_gnt out 1, if_rvalid out 1, if_rdata out DW.
REQ-006 SHALL have data ports: d_req in 1, d_we in 1, d_be in 4, d_addr in AW, d_wdata in DW, d_gnt out 1, d_rvalid out 1, d_rdata out DW.
REQ-007 SHALL have memory ports: mem_rd_req out 1, mem_wr_req out 1, mem_be out 4, mem_addr out AW, mem_wdata out DW, mem_rd_data in DW (valid the cycle after mem_rd_req).
REQ-008 SHALL have stall outputs if_stall and d_stall, each 1 bit, equal to req & ~gnt.

Function
REQ-009 SHALL grant at most one requester per cycle; the grant is combinational from the current cycle's inputs and state.
REQ-010 SHALL drive the mem_* request signals from the granted requester. When no grant is given, mem_rd_req, mem_wr_req, mem_be, mem_addr and mem_wdata SHALL be 0.
REQ-011 Fetch grant SHALL produce mem_rd_req=1 and mem_be=4'hF.
REQ-012 Data grant with d_we=1 SHALL produce mem_wr_req=1. Data grant with d_we=0 SHALL produce mem_rd_req=1. In both cases mem_be=d_be.
REQ-013 SHALL track the read-return owner in an FSM with states IDLE, RD_IF and RD_D.
REQ-014 FSM state after the clock edge SHALL be: RD_IF after a fetch read grant; RD_D after a data read grant; otherwise IDLE.
REQ-015 In state RD_IF, SHALL assert if_rvalid=1 with if_rdata=mem_rd_data. In state RD_D, SHALL assert d_rvalid=1 with d_rdata=mem_rd_data.
REQ-016 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
REQ-017 Back-to-back reads SHALL be supported: a grant may be given in RD_IF or RD_D, giving fully pipelined single-cycle reads.
REQ-018 Arbitration (default) SHALL be fixed priority, data over fetch.
REQ-019 SHALL keep a 4-bit starvation counter that increments on each cycle with if_req & ~if_gnt, saturates at STARVE_MAX, and clears on an if_gnt cycle.
REQ-020 When the counter equals STARVE_MAX and both requesters are active, SHALL grant fetch.
REQ-021 A sole requester SHALL always be granted in the same cycle.
REQ-022 A data write granted in the same cycle that a read return is delivered SHALL be legal; both actions SHALL occur.

Reset
REQ-023 While rst=1, SHALL hold: FSM in IDLE, starvation counter 0, RR pointer 0, all outputs 0.
REQ-024 Reset asserted mid-read SHALL drop the pending return; no rvalid SHALL be asserted after rst deasserts until a new grant.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, SHALL replace REQ-018..REQ-020 with round-robin arbitration: a 1-bit pointer marks the last-granted requester, and on contention the other requester wins; the starvation counter SHALL be absent.
REQ-026 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority with the starvation counter.

Structure
REQ-027 A shared package riscv_mem_pkg SHALL hold: the FSM enum (IDLE/RD_IF/RD_D), the owner enum (OWN_IF/OWN_D), and constants BE_WORD=4'hF and STARVE_W=4.
REQ-028 A single sub-module riscv_arb_pick SHALL compute the grant from the two requests, the starvation count or RR pointer, and the configuration.

Verification
REQ-029 Scenario: fetch-only read if_addr=0x100, mem_rd_data=0xDEADBEEF next cycle -> if_gnt=1 same cycle; if_rvalid=1 and if_rdata=0xDEADBEEF one cycle later; d_rvalid=0.
REQ-030 Scenario: both request (data read 0x200) -> d_gnt=1, if_stall=1; next cycle d_rvalid=1 and if_rvalid=0.
REQ-031 Scenario: d_req held high 6 cycles alongside if_req, STARVE_MAX=4 -> if_gnt=1 on cycle 5 only, counter clears, d_stall=1 on that cycle.
REQ-032 Scenario: alternating read then write (d_we=1, d_be=4'b0011, d_wdata=0x1234) -> write issues mem_wr_req=1 in the same cycle as the preceding read's rvalid.
REQ-033 Scenario: rst pulsed in the cycle after a data read grant -> d_rvalid stays 0; FSM is IDLE.
REQ-034 Scenario (ARB_ROUND_ROBIN_EN): continuous dual requests -> grants alternate IF, D, IF, D starting with IF after reset.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch/data memory arbiter: read-owner FSM states, owner ids, constants.
// Arbitration mode is selected by ARB_ROUND_ROBIN_EN (see riscv_mem_arbiter).
package riscv_mem_pkg;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam int         STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } rd_state_t;

    // OWN_D is the reset value of the round-robin pointer, so fetch wins first contention.
    typedef enum logic {
        OWN_D  = 1'b0,
        OWN_IF = 1'b1
    } owner_t;

endpackage

// File: rtl/riscv_arb_pick.sv
// Combinational two-way grant: fixed data priority with starvation override, or round-robin
// when ARB_ROUND_ROBIN_EN is defined. Zero latency; a sole requester is always granted.
module riscv_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                i_if_req,
    input  logic                i_d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic                i_rr_last,
`else
    input  logic [STARVE_W-1:0] i_starve_cnt,
`endif
    output logic                o_if_gnt,
    output logic                o_d_gnt
);

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
`endif

    logic w_fav_if;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        w_fav_if = (i_rr_last == OWN_D);
`else
        w_fav_if = (i_starve_cnt == STARVE_LIM);
`endif
        o_if_gnt = 1'b0;
        o_d_gnt  = 1'b0;
        if (i_if_req && i_d_req) begin
            o_if_gnt = w_fav_if;
            o_d_gnt  = !w_fav_if;
        end else begin
            o_if_gnt = i_if_req;
            o_d_gnt  = i_d_req;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-cycle memory port between fetch and data; grant is same-cycle, read data
// returns one cycle later. ARB_ROUND_ROBIN_EN selects round-robin instead of priority+starvation.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_rd_req,
    output logic          mem_wr_req,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rd_data,
    output logic          if_stall,
    output logic          d_stall
);

    logic      w_if_req, w_d_req, w_if_gnt, w_d_gnt;
    rd_state_t r_state, w_state_nxt;

    // Requests are masked during reset so every output, including stalls, reads as 0.
    assign w_if_req = if_req & ~rst;
    assign w_d_req  = d_req & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_rr_last <= OWN_D;
        else if (w_if_gnt) r_rr_last <= OWN_IF;
        else if (w_d_gnt)  r_rr_last <= OWN_D;
    end

    riscv_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .i_if_req  (w_if_req),
        .i_d_req   (w_d_req),
        .i_rr_last (r_rr_last),
        .o_if_gnt  (w_if_gnt),
        .o_d_gnt   (w_d_gnt)
    );
`else
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    logic [STARVE_W-1:0] r_starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_starve_cnt <= '0;
        else if (w_if_gnt)                            r_starve_cnt <= '0;
        else if (w_if_req && r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    riscv_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .i_if_req     (w_if_req),
        .i_d_req      (w_d_req),
        .i_starve_cnt (r_starve_cnt),
        .o_if_gnt     (w_if_gnt),
        .o_d_gnt      (w_d_gnt)
    );
`endif

    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;
    assign if_stall = w_if_req & ~w_if_gnt;
    assign d_stall  = w_d_req & ~w_d_gnt;

    always_comb begin
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (w_if_gnt) begin
            mem_rd_req = 1'b1;
            mem_be     = BE_WORD;
            mem_addr   = if_addr;
        end else if (w_d_gnt) begin
            mem_rd_req = ~d_we;
            mem_wr_req = d_we;
            mem_be     = d_be;
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A new grant in RD_IF/RD_D simply overwrites the owner: reads are fully pipelined.
    always_comb begin
        w_state_nxt = IDLE;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        if_rdata    = '0;
        d_rdata     = '0;
        if (w_if_gnt)              w_state_nxt = RD_IF;
        else if (w_d_gnt && !d_we) w_state_nxt = RD_D;
        if (r_state == RD_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rd_data;
        end
        if (r_state == RD_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rd_data;
        end
    end

endmodule
